// File: rtl/synfifo_pkg.sv
// Shared definitions for the synfifo_pro FIFO: read-mode selectors and a
// constant-evaluable ceiling log2 used to size pointers and the count port.
package synfifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Smallest n such that 2**n >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/synfifo_mem.sv
// DEPTH x WIDTH register-array storage for synfifo_pro: one synchronous write
// port and one asynchronous read port, storage intentionally left unreset.
module synfifo_mem
  import synfifo_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/synfifo_pro.sv
// Single-clock FIFO with occupancy count, programmable almost flags, selectable
// standard/FWFT read, synchronous flush and sticky overflow/underflow flags.
module synfifo_pro
  import synfifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = FIFO_STD,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              wpush,
  output logic              wfull,
  output logic              almost_full,
  output logic [WIDTH-1:0]  rdata,
  input  logic              rpop,
  output logic              rempty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_CMP  = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CMP  = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W:0]  r_waddr;
  logic [ADDR_W:0]  r_raddr;
  logic             r_overflow;
  logic             r_underflow;
  logic [ADDR_W:0]  w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wena;
  logic             w_rena;
  logic [WIDTH-1:0] w_memRdata;

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  assign w_empty = (r_waddr == r_raddr);
  assign w_full  = (r_waddr[ADDR_W] != r_raddr[ADDR_W]) &&
                   (r_waddr[ADDR_W-1:0] == r_raddr[ADDR_W-1:0]);
  assign w_count = r_waddr - r_raddr;

  assign w_wena = wpush && !w_full && !flush;
  assign w_rena = rpop && !w_empty && !flush;

  synfifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_wena),
    .waddr (r_waddr[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (r_raddr[ADDR_W-1:0]),
    .rdata (w_memRdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
    end else if (flush) begin
      r_waddr <= '0;
      r_raddr <= '0;
    end else begin
      if (w_wena) begin
        r_waddr <= r_waddr + PTR_ONE;
      end
      if (w_rena) begin
        r_raddr <= r_raddr + PTR_ONE;
      end
    end
  end

  // Error flags record the attempt, so they key off the raw request, not acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wpush && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rpop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign rdata = w_memRdata;
    end else begin : g_std
      logic [WIDTH-1:0] r_rdata;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (flush) begin
          r_rdata <= '0;
        end else if (w_rena) begin
          r_rdata <= w_memRdata;
        end
      end

      assign rdata = r_rdata;
    end
  endgenerate

  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_CMP);
  assign almost_empty = (w_count <= AE_CMP);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_synfifo_pro.sv
// Directed bench for synfifo_pro: one standard-read instance and one FWFT
// instance, each checked against hand-computed values after every clock.
module tb_synfifo_pro;

  logic        clk;
  logic        rst;

  logic        sFlush, sPush, sPop;
  logic [15:0] sWdata;
  logic        sFull, sAf, sEmpty, sAe, sOv, sUn;
  logic [15:0] sRdata;
  logic [3:0]  sCount;

  logic        fFlush, fPush, fPop;
  logic [15:0] fWdata;
  logic        fFull, fAf, fEmpty, fAe, fOv, fUn;
  logic [15:0] fRdata;
  logic [3:0]  fCount;

  int checks;
  int failures;

  synfifo_pro #(
    .WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)
  ) dutStd (
    .clk(clk), .rst(rst), .flush(sFlush), .wdata(sWdata), .wpush(sPush),
    .wfull(sFull), .almost_full(sAf), .rdata(sRdata), .rpop(sPop),
    .rempty(sEmpty), .almost_empty(sAe), .count(sCount),
    .overflow(sOv), .underflow(sUn)
  );

  synfifo_pro #(
    .WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)
  ) dutFw (
    .clk(clk), .rst(rst), .flush(fFlush), .wdata(fWdata), .wpush(fPush),
    .wfull(fFull), .almost_full(fAf), .rdata(fRdata), .rpop(fPop),
    .rempty(fEmpty), .almost_empty(fAe), .count(fCount),
    .overflow(fOv), .underflow(fUn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle on the selected instance (0 = standard, 1 = FWFT) with
  // the other idle, then returns 1 ns after the edge for sampling.
  task automatic applyStimulus(input int sel, input logic push, input logic [15:0] data,
                               input logic pop, input logic fl);
    sPush = 1'b0; sPop = 1'b0; sFlush = 1'b0; sWdata = '0;
    fPush = 1'b0; fPop = 1'b0; fFlush = 1'b0; fWdata = '0;
    if (sel == 0) begin
      sPush = push; sWdata = data; sPop = pop; sFlush = fl;
    end else begin
      fPush = push; fWdata = data; fPop = pop; fFlush = fl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sPush = 1'b0; sPop = 1'b0; sFlush = 1'b0; sWdata = '0;
    fPush = 1'b0; fPop = 1'b0; fFlush = 1'b0; fWdata = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_count",  32'(sCount), 0);
    checkOutput("rst_empty",  32'(sEmpty), 1);
    checkOutput("rst_full",   32'(sFull), 0);
    checkOutput("rst_ae",     32'(sAe), 1);
    checkOutput("rst_af",     32'(sAf), 0);
    checkOutput("rst_rdata",  32'(sRdata), 0);
    checkOutput("rst_ov",     32'(sOv), 0);
    checkOutput("rst_un",     32'(sUn), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1'b1, 16'(i), 1'b0, 1'b0);
      checkOutput($sformatf("fill_count%0d", i), 32'(sCount), 32'(i));
      checkOutput($sformatf("fill_af%0d", i), 32'(sAf), 32'(i >= 6));
      checkOutput($sformatf("fill_ae%0d", i), 32'(sAe), 32'(i <= 1));
      checkOutput($sformatf("fill_full%0d", i), 32'(sFull), 32'(i == 8));
    end

    // Push while full
    applyStimulus(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(sCount), 8);
    checkOutput("ovf_flag", 32'(sOv), 1);
    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("ovf_sticky", 32'(sOv), 1);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("drain_rdata%0d", i), 32'(sRdata), 32'(i));
      checkOutput($sformatf("drain_count%0d", i), 32'(sCount), 32'(8 - i));
    end
    checkOutput("drain_empty", 32'(sEmpty), 1);
    checkOutput("drain_ov_held", 32'(sOv), 1);

    // Pop while empty
    applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("unf_flag", 32'(sUn), 1);
    checkOutput("unf_rdata", 32'(sRdata), 8);
    checkOutput("unf_count", 32'(sCount), 0);

    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("flush1_ov", 32'(sOv), 0);
    checkOutput("flush1_un", 32'(sUn), 0);
    checkOutput("flush1_rdata", 32'(sRdata), 0);

    // Simultaneous push/pop at count 4
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 16'h0014, 1'b1, 1'b0);
    checkOutput("mid_pp_count", 32'(sCount), 4);
    checkOutput("mid_pp_rdata", 32'(sRdata), 'h10);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("mid_drain%0d", i), 32'(sRdata), 32'('h10 + i));
    end
    checkOutput("mid_empty", 32'(sEmpty), 1);

    // Simultaneous push/pop at full
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 16'(16'h20 + i), 1'b0, 1'b0);
    checkOutput("full2_full", 32'(sFull), 1);
    applyStimulus(0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("full_pp_count", 32'(sCount), 7);
    checkOutput("full_pp_ov", 32'(sOv), 1);
    checkOutput("full_pp_rdata", 32'(sRdata), 'h20);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("full_drain%0d", i), 32'(sRdata), 32'('h20 + i));
    end
    checkOutput("full_drain_empty", 32'(sEmpty), 1);

    // Simultaneous push/pop at empty
    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 16'h0030, 1'b1, 1'b0);
    checkOutput("empty_pp_count", 32'(sCount), 1);
    checkOutput("empty_pp_un", 32'(sUn), 1);
    checkOutput("empty_pp_rdata", 32'(sRdata), 0);
    applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("empty_pp_pop", 32'(sRdata), 'h30);

    // Wrap-around with 3 resident entries
    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 16'(16'h40 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1'b1, 16'(16'h43 + k), 1'b1, 1'b0);
      checkOutput($sformatf("wrap_count%0d", k), 32'(sCount), 3);
      checkOutput($sformatf("wrap_rdata%0d", k), 32'(sRdata), 32'('h40 + k));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("wrap_tail%0d", i), 32'(sRdata), 32'('h54 + i));
    end

    // Flush with push at count 5 and overflow set
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 16'(16'h60 + i), 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("pre_flush_count", 32'(sCount), 5);
    checkOutput("pre_flush_ov", 32'(sOv), 1);
    applyStimulus(0, 1'b1, 16'h1234, 1'b0, 1'b1);
    checkOutput("flush_count", 32'(sCount), 0);
    checkOutput("flush_empty", 32'(sEmpty), 1);
    checkOutput("flush_ov", 32'(sOv), 0);
    checkOutput("flush_rdata", 32'(sRdata), 0);
    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("flush_push_ignored", 32'(sCount), 0);

    // Asynchronous reset mid-burst
    applyStimulus(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 16'(16'h70 + i), 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 16'h0073, 1'b1, 1'b0);
    checkOutput("burst_rdata", 32'(sRdata), 'h70);
    checkOutput("burst_un", 32'(sUn), 1);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(sCount), 0);
    checkOutput("arst_empty", 32'(sEmpty), 1);
    checkOutput("arst_ae", 32'(sAe), 1);
    checkOutput("arst_rdata", 32'(sRdata), 0);
    checkOutput("arst_un", 32'(sUn), 0);
    checkOutput("arst_full", 32'(sFull), 0);
    sPush = 1'b0; sPop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("post_rst_empty", 32'(sEmpty), 1);

    // FWFT instance
    applyStimulus(1, 1'b1, 16'h00AA, 1'b0, 1'b0);
    checkOutput("fw_aa_rdata", 32'(fRdata), 'hAA);
    checkOutput("fw_aa_empty", 32'(fEmpty), 0);
    applyStimulus(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("fw_pop_empty", 32'(fEmpty), 1);
    checkOutput("fw_pop_count", 32'(fCount), 0);
    applyStimulus(1, 1'b1, 16'h00BB, 1'b0, 1'b0);
    checkOutput("fw_bb_rdata", 32'(fRdata), 'hBB);
    applyStimulus(1, 1'b1, 16'h00CC, 1'b1, 1'b0);
    checkOutput("fw_cc_rdata", 32'(fRdata), 'hCC);
    checkOutput("fw_cc_count", 32'(fCount), 1);
    applyStimulus(1, 1'b1, 16'h00DD, 1'b0, 1'b0);
    checkOutput("fw_dd_head", 32'(fRdata), 'hCC);
    checkOutput("fw_dd_count", 32'(fCount), 2);
    applyStimulus(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("fw_dd_rdata", 32'(fRdata), 'hDD);
    applyStimulus(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("fw_unf", 32'(fUn), 1);
    checkOutput("fw_final_empty", 32'(fEmpty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
